autoencoder_sequencer: RTL

//  Program sequencer for the autoencoder datapath. Replaces the free-running instruction counter.
//  - Fetches from the synchronous instruction memory.
//  - Issues one instruction at a time to the CU/ALU path, with a stall on dp_busy.
//  - Handles HALT and epoch LOOP opcodes internally.
//  - Reports completion to the host with a start/done handshake.

---
 rtl/autoencoder_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/autoencoder_sequencer.sv
// Program sequencer for the autoencoder datapath: fetch, issue with dp_busy stall, HALT/LOOP, start/done.
// Optional single-step gating of normal issues is enabled by defining SEQ_SINGLE_STEP_EN.
module autoencoder_sequencer #(
  parameter int          ADDR_W  = 5,
  parameter int          INSTR_W = 16,
  parameter int          EPOCH_W = 8,
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter logic [3:0]  LOOP_OP = 4'hE
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [EPOCH_W-1:0] epochs_i,
  output logic [ADDR_W-1:0]  instr_addr_o,
  input  logic [INSTR_W-1:0] instr_data_i,
  output logic               issue_valid_o,
  output logic [INSTR_W-1:0] issue_instr_o,
  input  logic               dp_busy_i,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step_i,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic [EPOCH_W-1:0] epoch_left_o,
  output logic               err_overrun_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0]  PC_ZERO    = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  PC_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]  PC_LAST    = {ADDR_W{1'b1}};
  localparam logic [EPOCH_W-1:0] EPOCH_ZERO = {EPOCH_W{1'b0}};
  localparam logic [EPOCH_W-1:0] EPOCH_ONE  = {{(EPOCH_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic                 err_q, err_d;
  logic                 issue_valid_q, issue_valid_d;
  logic [INSTR_W-1:0]   issue_instr_q, issue_instr_d;
  logic                 busy_q, done_q;
  logic [3:0]           opcode_s;
  logic                 issue_ok_s;

  assign opcode_s = instr_data_i[INSTR_W-1 -: 4];

`ifdef SEQ_SINGLE_STEP_EN
  assign issue_ok_s = (~dp_busy_i) & step_i;
`else
  assign issue_ok_s = ~dp_busy_i;
`endif

  // Next-state and datapath update logic for the sequencer FSM
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epoch_d       = epoch_q;
    err_d         = err_q;
    issue_valid_d = 1'b0;
    issue_instr_d = issue_instr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pc_d    = PC_ZERO;
          epoch_d = epochs_i;
          err_d   = 1'b0;
          if (epochs_i == EPOCH_ZERO) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (opcode_s == HALT_OP) begin
          state_d = S_DONE;
        end else if (opcode_s == LOOP_OP) begin
          if (epoch_q > EPOCH_ONE) begin
            epoch_d = epoch_q - EPOCH_ONE;
            pc_d    = instr_data_i[ADDR_W-1:0];
            state_d = S_FETCH;
          end else begin
            epoch_d = EPOCH_ZERO;
            // Fall-through past the last word is an overrun, never a wrap
            if (pc_q == PC_LAST) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              pc_d    = pc_q + PC_ONE;
              state_d = S_FETCH;
            end
          end
        end else if (issue_ok_s) begin
          issue_valid_d = 1'b1;
          issue_instr_d = instr_data_i;
          if (pc_q == PC_LAST) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; busy/done are derived from the next state
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      pc_q          <= PC_ZERO;
      epoch_q       <= EPOCH_ZERO;
      err_q         <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= {INSTR_W{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epoch_q       <= epoch_d;
      err_q         <= err_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_DONE);
    end
  end

  assign instr_addr_o  = pc_q;
  assign issue_valid_o = issue_valid_q;
  assign issue_instr_o = issue_instr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign epoch_left_o  = epoch_q;
  assign err_overrun_o = err_q;

endmodule
